// File: rtl/useq_pkg.sv
// Shared definitions for the decode-stage-2 microsequencer: state encoding,
// control-word field positions and default parameter values.
package useq_pkg;

    localparam int UADDR_W_DEF  = 8;
    localparam int CW_W_DEF     = 128;
    localparam int MAX_UOPS_DEF = 8;
    localparam int EIP_W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_INTR = 2'd2
    } useq_state_e;

    // UEND sits in the MSB of the control word.
    function automatic int uend_pos(input int cw_w);
        return cw_w - 32'sd1;
    endfunction

    // NEXT address field sits directly below UEND.
    function automatic int next_lsb(input int cw_w, input int uaddr_w);
        return cw_w - 32'sd1 - uaddr_w;
    endfunction

endpackage

// File: rtl/useq_rom.sv
// Combinational microcode ROM. The image is generated by a function at
// elaboration; each word carries UEND, NEXT and its own address in the low bits.
module useq_rom
    import useq_pkg::*;
#(
    parameter int UADDR_W = UADDR_W_DEF,
    parameter int CW_W    = CW_W_DEF
) (
    input  logic [UADDR_W-1:0] addr_i,
    output logic [CW_W-1:0]    word_o
);

    localparam int UEND_POS = uend_pos(CW_W);
    localparam int NEXT_LSB = next_lsb(CW_W, UADDR_W);

    // Multi-uop flows: 0x20-0x22, 0x40-0x4F (no terminator), handler 0xF0-0xF1.
    function automatic logic [CW_W-1:0] image_word(input logic [UADDR_W-1:0] a);
        logic [CW_W-1:0] w;
        logic [31:0]     ax;
        logic            uend;
        ax   = 32'(a);
        uend = 1'b1;
        if (ax == 32'h20 || ax == 32'h21 || ax == 32'hF0) begin
            uend = 1'b0;
        end else if (ax >= 32'h40 && ax <= 32'h4F) begin
            uend = 1'b0;
        end else begin
            uend = 1'b1;
        end
        w                        = '0;
        w[UADDR_W-1:0]           = a;
        w[NEXT_LSB +: UADDR_W]   = a + UADDR_W'(1'b1);
        w[UEND_POS]              = uend;
        return w;
    endfunction

    // ROM read
    always_comb begin
        word_o = image_word(addr_i);
    end

endmodule

// File: rtl/decode_useq_stage.sv
// Decode-stage-2 microsequencer: expands one instruction into 1..MAX_UOPS uops.
// Define USEQ_INT_EN to build the interrupt path and the INTR state.
module decode_useq_stage
    import useq_pkg::*;
#(
    parameter int UADDR_W  = UADDR_W_DEF,
    parameter int CW_W     = CW_W_DEF,
    parameter int MAX_UOPS = MAX_UOPS_DEF,
    parameter int EIP_W    = EIP_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UADDR_W-1:0] decode_addr,
    input  logic [3:0]         instr_len,
    input  logic [EIP_W-1:0]   eip_in,
    input  logic               int_req,
    input  logic [UADDR_W-1:0] int_vector,
    output logic               int_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW_W-1:0]    control_word,
    output logic [UADDR_W-1:0] uop_addr,
    output logic               uop_first,
    output logic               uop_last,
    output logic [EIP_W-1:0]   eip_out,
    output logic               seq_err
);

    localparam int              CNT_W    = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_UOPS - 1);
    localparam int              UEND_POS = uend_pos(CW_W);
    localparam int              NEXT_LSB = next_lsb(CW_W, UADDR_W);

    useq_state_e        state_q, state_d;
    logic               valid_q, valid_d;
    logic [UADDR_W-1:0] addr_q, addr_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic [EIP_W-1:0]   eip_q, eip_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic boundary_s;
    logic advance_s;
    logic take_int_s;

    // The ROM is read at the next address so the control word is registered.
    useq_rom #(.UADDR_W(UADDR_W), .CW_W(CW_W)) u_rom (
        .addr_i (addr_d),
        .word_o (cw_d)
    );

    // Handshake qualifiers and interrupt selection
    always_comb begin
        boundary_s = !valid_q || (last_q && out_ready);
        advance_s  = valid_q && out_ready && !last_q;
`ifdef USEQ_INT_EN
        take_int_s = boundary_s && int_req && !flush && (state_q != ST_INTR);
`else
        take_int_s = 1'b0;
`endif
    end

`ifndef USEQ_INT_EN
    logic unused_int_s;
    assign unused_int_s = ^{int_req, int_vector};
`endif

    assign in_ready = !reset && boundary_s && !take_int_s && !flush;
    assign int_ack  = !reset && take_int_s;

    // Sequencing: flush > interrupt > accept > advance > drain > hold
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        first_d = first_q;
        eip_d   = eip_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            first_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (take_int_s) begin
            valid_d = 1'b1;
            addr_d  = int_vector;
            first_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_INTR;
        end else if (boundary_s && in_valid) begin
            valid_d = 1'b1;
            addr_d  = decode_addr;
            first_d = 1'b1;
            cnt_d   = '0;
            eip_d   = eip_in + EIP_W'(instr_len);
            state_d = ST_RUN;
        end else if (advance_s) begin
            addr_d  = cw_q[NEXT_LSB +: UADDR_W];
            first_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1'b1);
        end else if (boundary_s) begin
            valid_d = 1'b0;
            first_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Last-uop and sticky overrun flags derived from the next control word
    always_comb begin
        last_d = valid_d && (cw_d[UEND_POS] || (cnt_d == CNT_LAST));
        err_d  = err_q || (valid_d && (cnt_d == CNT_LAST) && !cw_d[UEND_POS]);
    end

    // Output and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            cw_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            eip_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cw_q    <= cw_d;
            first_q <= first_d;
            last_q  <= last_d;
            eip_q   <= eip_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign control_word = cw_q;
    assign uop_addr     = addr_q;
    assign uop_first    = first_q;
    assign uop_last     = last_q;
    assign eip_out      = eip_q;
    assign seq_err      = err_q;

endmodule

// File: tb/tb_decode_useq_stage.sv
// Scoreboard bench for decode_useq_stage: stimulus pushes expected uops, a
// negedge monitor compares every presented uop against the queue head.
module tb_decode_useq_stage;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  cwlo;
        logic        first;
        logic        last;
        logic [31:0] eip;
        logic        err;
        logic        uend;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready;
    logic [7:0]   decode_addr;
    logic [3:0]   instr_len;
    logic [31:0]  eip_in;
    logic         int_req;
    logic [7:0]   int_vector;
    logic         int_ack, out_valid, out_ready;
    logic [127:0] control_word;
    logic [7:0]   uop_addr;
    logic         uop_first, uop_last;
    logic [31:0]  eip_out;
    logic         seq_err;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cur_eip = 32'h0;
    logic        err_sticky = 1'b0;
    int          w;

    decode_useq_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .decode_addr(decode_addr), .instr_len(instr_len), .eip_in(eip_in),
        .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_word(control_word), .uop_addr(uop_addr),
        .uop_first(uop_first), .uop_last(uop_last),
        .eip_out(eip_out), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_flags"}, {58'd0, out_valid, in_ready, int_ack, uop_first, uop_last, seq_err}, 64'd0);
        check({name, "_addr"}, {56'd0, uop_addr}, 64'd0);
        check({name, "_eip"}, {32'd0, eip_out}, 64'd0);
        check({name, "_cw_lo"}, control_word[63:0], 64'd0);
        check({name, "_cw_hi"}, control_word[127:64], 64'd0);
    endtask

    // Expected uops of a sequential chain starting at a0.
    task automatic push_chain(input logic [7:0] a0, input int n, input bit forced);
        exp_t r;
        for (int i = 0; i < n; i++) begin
            r.addr  = a0 + 8'(i);
            r.cwlo  = r.addr;
            r.first = (i == 0);
            r.last  = (i == n - 1);
            r.uend  = r.last && !forced;
            if (forced && r.last) err_sticky = 1'b1;
            r.err   = err_sticky;
            r.eip   = cur_eip;
            q.push_back(r);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] len, input logic [31:0] eip,
                         input int n, input bit forced, output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        decode_addr = a;
        instr_len   = len;
        eip_in      = eip;
        in_valid    = 1'b1;
        while (!got && waits < 40) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                check("ack_at_accept", {63'd0, int_ack}, 64'd0);
                cur_eip = eip + {28'd0, len};
                push_chain(a, n, forced);
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        check("accept_timeout", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: every presented uop must match the queue head; pop on handshake
    always @(negedge clk) begin
        exp_t act;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_uop", {63'd0, out_valid}, 64'd0);
            end else begin
                act.addr  = uop_addr;
                act.cwlo  = control_word[7:0];
                act.first = uop_first;
                act.last  = uop_last;
                act.eip   = eip_out;
                act.err   = seq_err;
                act.uend  = control_word[127];
                check("uop", 64'(act), 64'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    logic t2_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic t2_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; decode_addr = 8'h00;
        instr_len = 4'd0; eip_in = 32'h0; int_req = 1'b0; int_vector = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // single uop
        issue(8'h10, 4'd3, 32'h0000_1000, 1, 1'b0, w);
        drain();

        // 3-uop chain with a 2-cycle stall on 0x21
        issue(8'h20, 4'd2, 32'h0000_1100, 3, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            out_ready = t2_rdy[i];
            @(negedge clk);
            check("t2_in_ready", {63'd0, in_ready}, {63'd0, t2_exp[i]});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_idle", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;

        // back-to-back single uops, including EIP wrap
        issue(8'h11, 4'd1, 32'h0000_2000, 1, 1'b0, w);
        issue(8'h12, 4'd15, 32'hFFFF_FFFE, 1, 1'b0, w);
        check("t3_no_bubble", 64'(w), 64'd0);
        issue(8'h13, 4'd4, 32'h0000_3000, 1, 1'b0, w);
        check("t3_no_bubble", 64'(w), 64'd0);
        drain();

        // chain without UEND hits MAX_UOPS
        issue(8'h40, 4'd5, 32'h0000_4000, 8, 1'b1, w);
        drain();
        issue(8'h10, 4'd1, 32'h0000_4100, 1, 1'b0, w);
        drain();
        @(negedge clk);
        check("t4_err_sticky", {63'd0, seq_err}, 64'd1);
        @(posedge clk); #1;

        // interrupt versus instruction at a boundary
`ifdef USEQ_INT_EN
        int_vector = 8'hF0; int_req = 1'b1;
        decode_addr = 8'h12; instr_len = 4'd2; eip_in = 32'h0000_5000; in_valid = 1'b1;
        @(negedge clk);
        check("t5_int_ack", {63'd0, int_ack}, 64'd1);
        check("t5_in_ready_low", {63'd0, in_ready}, 64'd0);
        push_chain(8'hF0, 2, 1'b0);
        @(posedge clk); #1;
        int_req = 1'b0;
        issue(8'h12, 4'd2, 32'h0000_5000, 1, 1'b0, w);
        check("t5_wait_handler", 64'(w), 64'd1);
`else
        int_vector = 8'hF0; int_req = 1'b1;
        issue(8'h12, 4'd2, 32'h0000_5000, 1, 1'b0, w);
        check("t5_int_ignored", 64'(w), 64'd0);
        int_req = 1'b0;
`endif
        drain();

        // flush on uop 2 of 3 with a pending interrupt
        issue(8'h20, 4'd4, 32'h0000_6000, 3, 1'b0, w);
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b0; int_req = 1'b1; int_vector = 8'hF0;
        @(negedge clk);
        check("t6_flush_in_ready", {63'd0, in_ready}, 64'd0);
        check("t6_flush_no_ack", {63'd0, int_ack}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        q.delete();
        @(negedge clk);
        check("t6_flush_valid", {63'd0, out_valid}, 64'd0);
`ifdef USEQ_INT_EN
        check("t6_int_after_flush", {63'd0, int_ack}, 64'd1);
        push_chain(8'hF0, 2, 1'b0);
`else
        check("t6_int_after_flush", {63'd0, int_ack}, 64'd0);
`endif
        @(posedge clk); #1;
        int_req = 1'b0;
        drain();

        // reset mid-chain
        issue(8'h20, 4'd1, 32'h0000_7000, 3, 1'b0, w);
        out_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        q.delete();
        @(negedge clk);
        check_zero("reset_mid");
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1; err_sticky = 1'b0;
        @(negedge clk);
        check("ready_after_reset2", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        issue(8'h10, 4'd2, 32'h0000_8000, 1, 1'b0, w);
        drain();
        @(negedge clk);
        check("final_idle", {63'd0, out_valid}, 64'd0);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
